// File: rtl/delay_pkg.sv
// Shared constants, stage record type and a constant-evaluable clog2 for the
// programmable delay line.
package delay_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MAX_DLY = 16;

    typedef struct packed {
        logic                 vld;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

    // Number of bits needed to encode the values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One delay-line stage: a {vld, data} register with load enable, a valid-only
// clear, and synchronous active-low reset.
module delay_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             vclr_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    // A load takes its valid from the upstream side, which already folds in any
    // clear; a plain clear drops only the valid tag and keeps the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (ld_i) begin
            vld_q  <= vld_i;
            data_q <= data_i;
        end else if (vclr_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: MAX_DLY shift stages with valid tags, a
// clamped delay select, stall, flush and a zero-delay combinational bypass.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int DW      = clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DW-1:0]    dly_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             dly_err
);

    localparam logic [DW-1:0] MAX_Q = DW'(MAX_DLY);

    logic [DW-1:0]    dly_q;
    logic [DW-1:0]    dly_d;
    logic             dly_err_q;
    logic             over;
    logic             chg;
    logic             shift_en;
    logic             vclr;
    logic             tap_vld;
    logic [WIDTH-1:0] tap_data;

    logic             in_vld   [MAX_DLY];
    logic [WIDTH-1:0] in_data  [MAX_DLY];
    logic             stg_vld  [MAX_DLY];
    logic [WIDTH-1:0] stg_data [MAX_DLY];

    assign over     = (dly_sel > MAX_Q);
    assign dly_d    = over ? MAX_Q : dly_sel;
    assign chg      = (dly_d != dly_q);
    assign shift_en = en & ~clr;
    assign vclr     = clr | chg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_q     <= '0;
            dly_err_q <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            dly_err_q <= over;
        end
    end

    // On a delay change every in-flight tag is killed, but the head stage still
    // accepts the word presented at the change edge.
    for (genvar i = 0; i < MAX_DLY; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign in_vld[i]  = din_vld;
            assign in_data[i] = din;
        end else begin : g_body
            assign in_vld[i]  = stg_vld[i-1] & ~chg;
            assign in_data[i] = stg_data[i-1];
        end

        delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld_i   (shift_en),
            .vclr_i (vclr),
            .vld_i  (in_vld[i]),
            .data_i (in_data[i]),
            .vld_o  (stg_vld[i]),
            .data_o (stg_data[i])
        );
    end

    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (dly_q == DW'(i + 1)) begin
                tap_vld  = stg_vld[i];
                tap_data = stg_data[i];
            end
        end
    end

    // Outputs are forced low during reset so the bypass cannot leak din.
    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        if (rst_n) begin
            if (dly_q == '0) begin
                dout     = din;
                dout_vld = din_vld & en;
            end else begin
                dout     = tap_data;
                dout_vld = tap_vld;
            end
        end
    end

    assign dly_err = rst_n & dly_err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line: directed table, corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_prog_delay_line;
    import delay_pkg::*;

    localparam int W  = 16;
    localparam int MD = 16;
    localparam int DW = 5;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic [DW-1:0] dly_sel;
    logic [W-1:0]  din;
    logic          din_vld;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic          dly_err;

    prog_delay_line #(.WIDTH(W), .MAX_DLY(MD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .dly_sel  (dly_sel),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dly_err  (dly_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each accepted valid sample is stamped with the count of
    // shifting edges; it is visible once that count has advanced by the delay.
    typedef struct {
        int          idx;
        logic [15:0] data;
    } rec_t;

    rec_t recs[$];
    int   shcnt = 0;
    int   mdly  = 0;
    logic merr  = 1'b0;

    logic          obs_vld;
    logic [W-1:0]  obs_dout;
    logic          obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rn, input logic e, input logic c,
                       input logic [DW-1:0] sel, input logic [W-1:0] d, input logic v);
        logic          ev;
        logic [W-1:0]  ed;
        logic          ee;
        int            eff;
        rst_n = rn; en = e; clr = c; dly_sel = sel; din = d; din_vld = v;
        @(negedge clk);
        ev = 1'b0; ed = '0; ee = 1'b0;
        if (rn) begin
            ee = merr;
            if (mdly == 0) begin
                ev = v & e;
                ed = d;
            end else begin
                foreach (recs[i]) begin
                    if (recs[i].idx == shcnt - mdly + 1) begin
                        ev = 1'b1;
                        ed = recs[i].data;
                    end
                end
            end
        end
        obs_vld = dout_vld; obs_dout = dout; obs_err = dly_err;
        chk("model_vld", {31'b0, dout_vld}, {31'b0, ev});
        chk("model_err", {31'b0, dly_err}, {31'b0, ee});
        if (ev || !rn) chk("model_dout", {16'b0, dout}, {16'b0, ed});
        @(posedge clk);
        if (!rn) begin
            recs.delete();
            mdly = 0;
            merr = 1'b0;
        end else begin
            eff  = (int'(sel) > MD) ? MD : int'(sel);
            merr = (int'(sel) > MD);
            if (c) begin
                recs.delete();
            end else begin
                if (eff != mdly) recs.delete();
                if (e) begin
                    shcnt++;
                    if (v) recs.push_back('{shcnt, d});
                end
            end
            mdly = eff;
        end
        while (recs.size() > 0 && shcnt - recs[0].idx >= MD) void'(recs.pop_front());
        #1;
    endtask

    typedef struct {
        logic          rn, e, c;
        logic [DW-1:0] sel;
        logic [W-1:0]  d;
        logic          v;
        logic          xv;
        logic [W-1:0]  xd;
        logic          xe;
    } vec_t;

    vec_t vt[12];

    initial begin
        int n;
        int cnt;
        logic [DW-1:0] s;

        vt[0]  = '{1'b0, 1'b1, 1'b0, 5'd3,  16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 5'd3,  16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 5'd20, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd20, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vt[10] = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vt[11] = '{1'b1, 1'b1, 1'b0, 5'd3,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; dly_sel = '0; din = '0; din_vld = 1'b0;
        @(posedge clk); #1;
        recs.delete(); mdly = 0; merr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].rn, vt[i].e, vt[i].c, vt[i].sel, vt[i].d, vt[i].v);
            chk($sformatf("tbl%0d_vld", i), {31'b0, obs_vld}, {31'b0, vt[i].xv});
            chk($sformatf("tbl%0d_err", i), {31'b0, obs_err}, {31'b0, vt[i].xe});
            if (vt[i].xv || !vt[i].rn)
                chk($sformatf("tbl%0d_dout", i), {16'b0, obs_dout}, {16'b0, vt[i].xd});
        end

        // Bypass: dout follows din in the same cycle.
        cyc(1, 1, 0, 5'd0, 16'h1111, 1'b0);
        cyc(1, 1, 0, 5'd0, 16'h1234, 1'b1);
        chk("byp_dout", {16'b0, obs_dout}, 32'h1234);
        chk("byp_vld", {31'b0, obs_vld}, 32'd1);
        cyc(1, 1, 0, 5'd0, 16'h5678, 1'b1);
        chk("byp_dout2", {16'b0, obs_dout}, 32'h5678);

        // Stall at delay 2: en pattern 1,0,0,1 from the sample edge.
        cyc(1, 1, 0, 5'd2, 16'h0000, 1'b0);
        cyc(1, 1, 0, 5'd2, 16'hBEEF, 1'b1);
        cyc(1, 0, 0, 5'd2, 16'h0000, 1'b0);
        chk("stall_a", {31'b0, obs_vld}, 32'd0);
        cyc(1, 0, 0, 5'd2, 16'h0000, 1'b0);
        chk("stall_b", {31'b0, obs_vld}, 32'd0);
        cyc(1, 1, 0, 5'd2, 16'h0000, 1'b0);
        chk("stall_c", {31'b0, obs_vld}, 32'd0);
        cyc(1, 1, 0, 5'd2, 16'h0000, 1'b0);
        chk("stall_out_vld", {31'b0, obs_vld}, 32'd1);
        chk("stall_out_dout", {16'b0, obs_dout}, 32'hBEEF);

        // Delay change mid-stream 4 -> 2.
        for (int i = 1; i <= 9; i++) cyc(1, 1, 0, 5'd4, 16'(i), 1'b1);
        cyc(1, 1, 0, 5'd2, 16'd10, 1'b1);
        cyc(1, 1, 0, 5'd2, 16'd11, 1'b1);
        chk("chg_gap", {31'b0, obs_vld}, 32'd0);
        cyc(1, 1, 0, 5'd2, 16'd12, 1'b1);
        chk("chg_first_vld", {31'b0, obs_vld}, 32'd1);
        chk("chg_first_dout", {16'b0, obs_dout}, 32'd10);
        cyc(1, 1, 0, 5'd2, 16'd13, 1'b1);
        chk("chg_second_dout", {16'b0, obs_dout}, 32'd11);

        // Clamp: 20 selects the full 16 stages.
        cyc(1, 1, 0, 5'd20, 16'h0000, 1'b0);
        chk("clamp_err0", {31'b0, obs_err}, 32'd0);
        cyc(1, 1, 0, 5'd20, 16'h0000, 1'b0);
        chk("clamp_err1", {31'b0, obs_err}, 32'd1);
        cyc(1, 1, 0, 5'd20, 16'hC0DE, 1'b1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 1, 0, 5'd20, 16'h0000, 1'b0);
            if (obs_vld) begin
                n = i;
                break;
            end
        end
        chk("clamp_lat", n, 32'd16);
        chk("clamp_dout", {16'b0, obs_dout}, 32'hC0DE);

        // Flush colliding with a new sample while others are in flight.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 5'd4, 16'h0100 + 16'(i), 1'b1);
        cyc(1, 1, 1, 5'd4, 16'h0F0F, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 5'd4, 16'h0000, 1'b0);
            if (obs_vld) cnt++;
        end
        chk("flush_quiet", cnt, 32'd0);

        // Reset mid-operation drops in-flight samples.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 5'd3, 16'h0200 + 16'(i), 1'b1);
        cyc(0, 1, 0, 5'd3, 16'hFFFF, 1'b1);
        chk("rst_mid_vld", {31'b0, obs_vld}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 5'd3, 16'h0000, 1'b0);
            if (obs_vld) cnt++;
        end
        chk("rst_mid_quiet", cnt, 32'd0);

        // Randomized traffic against the model.
        s = 5'd5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) s = 5'($urandom_range(0, 21));
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) < 75),
                ($urandom_range(0, 99) < 3),
                s, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Parameterised, runtime-programmable delay line for the 16-bit RISC datapath. It generalises the fixed single-bit delay element to a WIDTH-bit data word with a valid tag, a delay selectable from 0 to MAX_DLY stages, stall (enable) support, and a synchronous flush. Control and pipeline paths use it to align operands, write-back tags and strobes whose required latency depends on the configuration.

## Interface
Parameters:
- WIDTH, 16: data width in bits.
- MAX_DLY, 16: number of physical stages and the maximum delay. Must be at least 1.
- DW, clog2(MAX_DLY+1): width of the delay-select port. Derived; do not override.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  advance enable; stages shift only when en=1.
- clr  in  1  synchronous flush of all valid tags.
- dly_sel  in  DW  requested delay, measured in en-cycles.
- din  in  WIDTH  input data.
- din_vld  in  1  input valid tag.
- dout  out  WIDTH  delayed data.
- dout_vld  out  1  delayed valid tag.
- dly_err  out  1  registered flag: the previous cycle's dly_sel exceeded MAX_DLY.

## Operation
- **Storage:** stage[0..MAX_DLY-1], each holding {vld, data}.
- **Shift:** on an edge with en=1, stage[0] loads {din_vld, din} and stage[i] loads stage[i-1].
- **Stall:** with en=0, all stages hold.
- **Effective delay:**
  - dly_eff = min(dly_sel, MAX_DLY).
  - It is registered into dly_q every cycle.
  - dly_err is registered as (dly_sel > MAX_DLY).
- **Output tap:**
  - If dly_q = 0: dout = din and dout_vld = din_vld & en. This is a combinational bypass.
  - Otherwise: dout = stage[dly_q-1].data and dout_vld = stage[dly_q-1].vld. The tap reads registered state, with no combinational path from din.
- **Delay change:** if dly_eff ≠ dly_q at an edge:
  - dly_q updates to dly_eff.
  - All stage vld bits clear. Data bits are retained.
  - If en=1 on that edge, stage[0] still loads din. No stale data is presented as valid after a change.
- **Flush (clr=1):**
  - All stage vld bits clear.
  - clr has priority over en: a din sample presented in the same cycle is dropped.
  - dly_q still updates.
- **Reset (rst_n=0 at an edge):**
  - All stage vld and data go to 0; dly_q = 0; dly_err = 0.
  - Reset has priority over clr, en and a delay change.
  - With dly_q=0 the output is in bypass, so dout_vld = din_vld & en. To keep dout_vld low during reset, gate the bypass with rst_n: dout=0 and dout_vld=0 while rst_n=0.
- **Reset mid-operation:** all in-flight samples are discarded. No sample presented before reset appears afterwards.

## Timing
- **Latency:**
  - A sample accepted at edge t with en held high appears on dout during cycle t+k, where k = dly_q.
  - In general, it appears after exactly k en=1 edges, counting the accepting edge as the first.
- **Pulse width:** a 1-cycle valid input produces exactly one cycle of dout_vld when en is held high.
- **New delay:** takes effect on the cycle after dly_sel changes. The first valid output under the new delay appears k en-edges after the change edge.
- **dly_err:** lags dly_sel by one cycle.
- **Reset values:** dout=0, dout_vld=0, dly_err=0.

## Structure
- Package delay_pkg holds:
  - the clog2 function,
  - the default WIDTH and MAX_DLY constants,
  - the typedef for a stage record {vld, data}.
- Sub-module delay_stage: one stage register with load enable, valid clear and synchronous reset. Instantiate it MAX_DLY times in a generate loop.
- The top level holds the dly_q register, change detection, clamp, dly_err, and the output tap multiplexer.

## Test plan
- **Reset:** rst_n=0 for 2 cycles with en=1, din=16'hFFFF, din_vld=1 → dout=0, dout_vld=0 and dly_err=0 throughout reset and on the first cycle after release.
- **Fixed delay:** dly_sel=3, en=1, a single din=16'hA5A5 with din_vld=1 at cycle t → dout=16'hA5A5 with dout_vld=1 only in cycle t+3.
- **Bypass and stall:**
  - dly_sel=0: dout tracks din in the same cycle.
  - Then dly_sel=2 with en pattern 1,0,0,1 from the sample edge → the sample emerges in the cycle after the second en=1 edge.
- **Delay change:**
  - Stream 16'h0001, 16'h0002, … at dly=4; switch to dly_sel=2 mid-stream.
  - dout_vld must be 0 on the next cycle, then resume 2 cycles after the change.
  - Resumed data must be the samples loaded at and after the change edge, in order, with no duplicates.
- **Clamp:** MAX_DLY=16, dly_sel=20 → dly_err=1 one cycle later, and a test sample emerges after 16 cycles.
- **Flush collision:** clr=1 and en=1 with din_vld=1 in the same cycle, with samples in flight → no dout_vld for any in-flight sample or for the colliding sample.
